fp_mul_pipe: RTL and testbench

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

---
 rtl/fp_mul_pipe.sv | 175 +++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage floating-point multiplier with valid/ready flow control.
// S1 unpacks and classifies, S2 multiplies mantissas, S3 normalises, rounds and packs.
// Optional macro FP_MUL_PIPE_ROUND_EN: round-to-nearest-even when defined, truncation otherwise.

module fp_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned P  = 2 * (MAN_W + 1);
  localparam int unsigned EW = EXP_W + 2;
  localparam logic signed [EW-1:0] Bias  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMax  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZero = '0;
  localparam logic [W-1:0] QNaN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {KNorm, KZero, KInf, KNan} kind_e;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // S1 combinational: field extraction and operand classification
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic signed [EW-1:0] e_sum;
  kind_e            kind_s1;

  assign ea     = a[W-2 -: EXP_W];
  assign eb     = b[W-2 -: EXP_W];
  assign fa     = a[MAN_W-1:0];
  assign fb     = b[MAN_W-1:0];
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (&ea) && (fa == '0);
  assign inf_b  = (&eb) && (fb == '0);
  assign nan_a  = (&ea) && (fa != '0);
  assign nan_b  = (&eb) && (fb != '0);
  assign e_sum  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - Bias;

  // Special-case priority: NaN / inf*0 beats infinity beats zero
  always_comb begin
    kind_s1 = KNorm;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
      kind_s1 = KNan;
    end else if (inf_a || inf_b) begin
      kind_s1 = KInf;
    end else if (zero_a || zero_b) begin
      kind_s1 = KZero;
    end
  end

  logic                 v1_q, s1_sign_q;
  kind_e                s1_kind_q;
  logic signed [EW-1:0] s1_exp_q;
  logic [MAN_W:0]       s1_ma_q, s1_mb_q;

  // S1 register: capture classified operands on advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_kind_q <= KNorm;
      s1_exp_q  <= '0;
      s1_ma_q   <= '0;
      s1_mb_q   <= '0;
    end else if (advance) begin
      v1_q      <= in_valid;
      s1_sign_q <= a[W-1] ^ b[W-1];
      s1_kind_q <= kind_s1;
      s1_exp_q  <= e_sum;
      s1_ma_q   <= {1'b1, fa};
      s1_mb_q   <= {1'b1, fb};
    end
  end

  logic                 v2_q, s2_sign_q;
  kind_e                s2_kind_q;
  logic signed [EW-1:0] s2_exp_q;
  logic [P-1:0]         s2_prod_q;

  // S2 register: full-width mantissa product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q      <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_kind_q <= KNorm;
      s2_exp_q  <= '0;
      s2_prod_q <= '0;
    end else if (advance) begin
      v2_q      <= v1_q;
      s2_sign_q <= s1_sign_q;
      s2_kind_q <= s1_kind_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= P'(s1_ma_q) * P'(s1_mb_q);
    end
  end

  // S3 combinational: normalise so the leading one sits just above sh[P-2]
  logic                 norm, guard_bit, sticky, inexact, round_up;
  logic [P-2:0]         sh;
  logic [MAN_W-1:0]     frac;
  logic [MAN_W:0]       frac_sum;
  logic signed [EW-1:0] e_fin;
  logic [W-1:0]         result_d;
  logic [3:0]           flags_d;

  assign norm      = s2_prod_q[P-1];
  assign sh        = norm ? s2_prod_q[P-2:0] : {s2_prod_q[P-3:0], 1'b0};
  assign frac      = sh[P-2 -: MAN_W];
  assign guard_bit = sh[MAN_W];
  assign sticky    = |sh[MAN_W-1:0];
  assign inexact   = guard_bit | sticky;
`ifdef FP_MUL_PIPE_ROUND_EN
  assign round_up  = guard_bit & (sticky | frac[0]);
`else
  assign round_up  = 1'b0;
`endif
  // A carry out of the fraction leaves it all-zero and bumps the exponent
  assign frac_sum  = {1'b0, frac} + (MAN_W+1)'(round_up);
  assign e_fin     = s2_exp_q + $signed(EW'(norm)) + $signed(EW'(frac_sum[MAN_W]));

  // S3 result selection: specials first, then range check on the rounded exponent
  always_comb begin
    result_d = '0;
    flags_d  = '0;
    unique case (s2_kind_q)
      KNan: begin
        result_d = QNaN;
        flags_d  = 4'b1000;
      end
      KInf:  result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      KZero: result_d = {s2_sign_q, {(W-1){1'b0}}};
      default: begin
        if (e_fin >= EMax) begin
          result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d  = 4'b0101;
        end else if (e_fin <= EZero) begin
          result_d = {s2_sign_q, {(W-1){1'b0}}};
          flags_d  = 4'b0011;
        end else begin
          result_d = {s2_sign_q, e_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
          flags_d  = {3'b000, inexact};
        end
      end
    endcase
  end

  // Output register: holds result/flags while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= v2_q;
      result    <= result_d;
      flags     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed and mixed-traffic bench for fp_mul_pipe (EXP_W=8, MAN_W=23).
// A queue-based scoreboard checks every valid output cycle against an integer-arithmetic model.

module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  int tests = 0;
  int fails = 0;
  logic [35:0] exp_q[$];

  fp_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference: value-level multiply, returns {flags, result}
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, sh;
    logic s;
    logic zx, zy, ix, iy, nx, ny, inex;
    longint unsigned mx, my, p, q, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    if (nx || ny || (ix && zy) || (zx && iy)) return {4'b1000, 32'h7FC0_0000};
    if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
    if (zx || zy) return {4'b0000, s, 31'h0};
    mx   = 64'h80_0000 + 64'(x[22:0]);
    my   = 64'h80_0000 + 64'(y[22:0]);
    p    = mx * my;
    sh   = ((p >> 47) != 0) ? 24 : 23;
    e    = ex + ey - 127 + (sh - 23);
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inex = (rem != 0);
`ifdef FP_MUL_PIPE_ROUND_EN
    if ((rem > half) || ((rem == half) && ((q & 64'd1) != 0))) q = q + 1;
`endif
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0011, s, 31'h0};
    return {3'b000, inex, s, 8'(e), q[22:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Scoreboard: record accepted pairs, compare every valid output against the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got %h/%h, required no output", result, flags);
        end else begin
          if ({flags, result} !== exp_q[0]) begin
            fails++;
            $display("FAIL sb_result: got %h, required %h", {flags, result}, exp_q[0]);
          end
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // One isolated op: latency and literal result/flags
  task automatic run_one(input string name, input logic [31:0] ta, input logic [31:0] tb,
                         input logic [31:0] er, input logic [3:0] ef);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({name, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'd3);
    check({name, "_res"}, 64'(result), 64'(er));
    check({name, "_flg"}, 64'(flags), 64'(ef));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  logic [31:0] va [8] = '{32'h3FC0_0000, 32'hC000_0000, 32'h3F80_0001, 32'h4049_0FDB,
                          32'hFF80_0000, 32'h7FC1_2345, 32'h0012_3456, 32'h5F80_0000};
  logic [31:0] vb [8] = '{32'h3FC0_0000, 32'h4040_0000, 32'h3F80_0001, 32'hC02D_F854,
                          32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h5F80_0000};
  logic [31:0] bpa [6] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                           32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};
  logic [31:0] er37;

  initial begin
    int sent, cyc, acc;
    logic took;
`ifdef FP_MUL_PIPE_ROUND_EN
    er37 = 32'h4010_0002;
`else
    er37 = 32'h4010_0001;
`endif
    // Reset state
    #1;
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_res", 64'(result), 64'd0);
    check("rst_flg", 64'(flags), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 64'(in_ready), 64'd1);

    // Pin the model against hand-computed values
    check("model_mul6", 64'(model(32'h4000_0000, 32'h4040_0000)), {28'h0, 4'h0, 32'h40C0_0000});
    check("model_rnd", 64'(model(32'h3FC0_0001, 32'h3FC0_0001)), {28'h0, 4'h1, er37});
    check("model_nan", 64'(model(32'h7F80_0000, 32'h0000_0000)), {28'h0, 4'h8, 32'h7FC0_0000});
    check("model_ovf", 64'(model(32'h7F00_0000, 32'h4000_0000)), {28'h0, 4'h5, 32'h7F80_0000});
    check("model_unf", 64'(model(32'h0080_0000, 32'h0080_0000)), {28'h0, 4'h3, 32'h0000_0000});

    // Directed single ops against literal expectations
    run_one("mul6", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000);
    run_one("rnd", 32'h3FC0_0001, 32'h3FC0_0001, er37, 4'b0001);
    run_one("inf_x_0", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000);
    run_one("negzero", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'b0000);
    run_one("ovf", 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0101);
    run_one("unf", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011);

    // Back-to-back directed stream at full throughput
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a = va[i]; b = vb[i]; in_valid = 1'b1; out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("stream");

    // Mixed traffic with random consumer stalls
    sent = 0; cyc = 0; took = 1'b0;
    while (sent < 40 && cyc < 2000) begin
      @(posedge clk); #1;
      if (!in_valid || took) begin
        a = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(90, 165)), 23'($urandom)};
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) sent++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain("random");

    // Backpressure: six cycles of in_valid with the consumer stalled
    @(posedge clk); #1;
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      a = bpa[acc]; b = 32'h4000_0000; in_valid = 1'b1;
      @(negedge clk);
      check("bp_rdy", 64'(in_ready), 64'(i < 3));
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_ov_held", 64'(out_valid), 64'd1);
    check("bp_res_head", 64'(result), 64'h4000_0000);
    out_ready = 1'b1;
    drain("bp");

    // Reset with two ops in flight: one at the output, one behind it
    @(posedge clk); #1;
    out_ready = 1'b0; a = 32'h4000_0000; b = 32'h4000_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h4040_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_ov", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_async_ov", 64'(out_valid), 64'd0);
    check("rst_async_res", 64'(result), 64'd0);
    check("rst_async_flg", 64'(flags), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_rdy", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
